// File: rtl/flash_bpi_pkg.sv
// Shared constants for the BPI flash responder: command codes, status bits
// and FSM state encodings.
package flash_bpi_pkg;

  localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;
  localparam logic [7:0] CMD_CLR_STATUS  = 8'h50;
  localparam logic [7:0] CMD_PROG        = 8'h40;
  localparam logic [7:0] CMD_PROG_ALT    = 8'h10;

  localparam int ST_READY = 7;
  localparam int ST_ERR   = 4;
  localparam int ST_BUSYV = 3;

  localparam logic [7:0] STATUS_RESET = 8'h80;

  localparam logic MODE_ARRAY  = 1'b0;
  localparam logic MODE_STATUS = 1'b1;

  localparam logic [1:0] BUS_IDLE    = 2'd0;
  localparam logic [1:0] BUS_RD_WAIT = 2'd1;
  localparam logic [1:0] BUS_RD_DATA = 2'd2;

  localparam logic [1:0] CST_CMD  = 2'd0;
  localparam logic [1:0] CST_ARM  = 2'd1;
  localparam logic [1:0] CST_BUSY = 2'd2;

  function automatic logic is_prog_cmd(input logic [7:0] b);
    return (b == CMD_PROG) || (b == CMD_PROG_ALT);
  endfunction

endpackage

// File: rtl/flash_bpi_sync.sv
// Parametrized 2-flop synchronizer with async active-low reset to RST_VAL.
module flash_bpi_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1, r_s2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/flash_bpi_responder.sv
// Device end of the 16-bit BPI NOR flash bus: small word array with read
// array / read status / word program / clear status commands.
module flash_bpi_responder
  import flash_bpi_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int MEM_AW   = 8,
  parameter int RD_LAT   = 4,
  parameter int PROG_CYC = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [15:0]       flash_dq_i,
  output logic [15:0]       flash_dq_o,
  output logic              flash_dq_oe,
  output logic              flash_wait,
  input  logic              flash_ce_n,
  input  logic              flash_oe_n,
  input  logic              flash_we_n
);

  logic [2:0]        w_strb_s;
  logic              w_ce_n, w_oe_n, w_we_n;
  logic              r_we_d;
  logic              w_wr_evt, w_wr_ok, w_wr_clash, w_prog_wr, w_rd_abort;
  logic [MEM_AW-1:0] w_idx;
  logic [7:0]        w_cmd;
  logic              w_unused_addr;

  flash_bpi_sync #(.W(3), .RST_VAL(3'b111)) u_sync (
    .CLK  (CLK),
    .RST_N(RST_N),
    .i_d  ({flash_ce_n, flash_oe_n, flash_we_n}),
    .o_q  (w_strb_s)
  );

  assign {w_ce_n, w_oe_n, w_we_n} = w_strb_s;
  assign w_idx         = flash_addr[MEM_AW-1:0];
  assign w_unused_addr = ^flash_addr[ADDR_W-1:MEM_AW];
  assign w_cmd         = flash_dq_i[7:0];

  // A write is the synced rising edge of we_n with the chip selected.
  assign w_wr_evt   = !r_we_d && w_we_n && !w_ce_n;
  assign w_wr_ok    = w_wr_evt && w_oe_n;
  assign w_wr_clash = w_wr_evt && !w_oe_n;
  assign w_rd_abort = w_oe_n || w_ce_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_we_d <= 1'b1;
    else        r_we_d <= w_we_n;
  end

  // ---------------- command FSM ----------------
  logic [1:0] r_cmd_st;
  logic       r_mode;
  logic [7:0] r_status;
  logic [7:0] r_prog_cnt;

  assign w_prog_wr = w_wr_ok && (r_cmd_st == CST_ARM);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cmd_st   <= CST_CMD;
      r_mode     <= MODE_ARRAY;
      r_status   <= STATUS_RESET;
      r_prog_cnt <= '0;
    end else begin
      if (w_wr_clash) r_status[ST_ERR] <= 1'b1;
      case (r_cmd_st)
        CST_CMD: begin
          if (w_wr_ok) begin
            if (is_prog_cmd(w_cmd)) begin
              r_cmd_st <= CST_ARM;
              r_mode   <= MODE_STATUS;
            end else begin
              case (w_cmd)
                CMD_READ_ARRAY:  r_mode <= MODE_ARRAY;
                CMD_READ_STATUS: r_mode <= MODE_STATUS;
                CMD_CLR_STATUS: begin
                  r_status[ST_ERR]   <= 1'b0;
                  r_status[ST_BUSYV] <= 1'b0;
                end
                default:         r_status[ST_ERR] <= 1'b1;
              endcase
            end
          end
        end
        CST_ARM: begin
          if (w_wr_ok) begin
            r_status[ST_READY] <= 1'b0;
            r_prog_cnt         <= '0;
            r_cmd_st           <= CST_BUSY;
          end
        end
        CST_BUSY: begin
          if (w_wr_ok) r_status[ST_BUSYV] <= 1'b1;
          if (r_prog_cnt == 8'(PROG_CYC - 1)) begin
            r_status[ST_READY] <= 1'b1;
            r_cmd_st           <= CST_CMD;
          end else begin
            r_prog_cnt <= r_prog_cnt + 8'd1;
          end
        end
        default: r_cmd_st <= CST_CMD;
      endcase
    end
  end

  // Stored inverted so a zero-initialised RAM reads back as erased 0xFFFF;
  // programming can only clear bits, i.e. only set bits of the inverted word.
  logic [15:0] r_mem_n [2**MEM_AW];

  always_ff @(posedge CLK) begin
    if (w_prog_wr) r_mem_n[w_idx] <= r_mem_n[w_idx] | ~flash_dq_i;
  end

  // ---------------- read (bus) FSM ----------------
  logic [1:0]        r_bus_st;
  logic [3:0]        r_lat_cnt;
  logic [MEM_AW-1:0] r_rd_idx;
  logic [15:0]       r_dq_o;
  logic              r_dq_oe, r_wait;
  logic [15:0]       w_rd_data;

  assign w_rd_data = (r_mode == MODE_STATUS || r_cmd_st == CST_BUSY)
                   ? {8'h00, r_status} : ~r_mem_n[r_rd_idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bus_st  <= BUS_IDLE;
      r_lat_cnt <= '0;
      r_rd_idx  <= '0;
      r_dq_o    <= '0;
      r_dq_oe   <= 1'b0;
      r_wait    <= 1'b0;
    end else if (w_rd_abort) begin
      r_bus_st <= BUS_IDLE;
      r_dq_o   <= '0;
      r_dq_oe  <= 1'b0;
      r_wait   <= 1'b0;
    end else begin
      case (r_bus_st)
        BUS_IDLE: begin
          if (w_we_n) begin
            r_bus_st  <= BUS_RD_WAIT;
            r_wait    <= 1'b1;
            r_lat_cnt <= '0;
            r_rd_idx  <= w_idx;
          end
        end
        BUS_RD_WAIT: begin
          if (r_lat_cnt == 4'(RD_LAT - 1)) begin
            r_bus_st <= BUS_RD_DATA;
            r_wait   <= 1'b0;
            r_dq_oe  <= 1'b1;
            r_dq_o   <= w_rd_data;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        BUS_RD_DATA: r_dq_o <= w_rd_data;
        default:     r_bus_st <= BUS_IDLE;
      endcase
    end
  end

  assign flash_dq_o  = r_dq_o;
  assign flash_dq_oe = r_dq_oe;
  assign flash_wait  = r_wait;

endmodule

// File: tb/tb_flash_bpi_responder.sv
// Directed bench for flash_bpi_responder with a cycle-level transaction model
// and a per-cycle compare of wait / dq_oe / dq_o.
module tb_flash_bpi_responder;

  localparam int ADDR_W = 24, MEM_AW = 8, RD_LAT = 4, PROG_CYC = 16;
  localparam int SYNC = 2;

  logic        CLK, RST_N;
  logic [23:0] addr;
  logic [15:0] dq_i, dq_o;
  logic        dq_oe, fwait, ce_n, oe_n, we_n;

  flash_bpi_responder #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .PROG_CYC(PROG_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .flash_addr(addr), .flash_dq_i(dq_i), .flash_dq_o(dq_o),
    .flash_dq_oe(dq_oe), .flash_wait(fwait), .flash_ce_n(ce_n), .flash_oe_n(oe_n), .flash_we_n(we_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // model state
  logic [15:0] m_mem [256];
  bit m_mode, m_err4, m_err3, m_armed;
  int busy_lo = 0, busy_hi = 0;
  bit chk_en = 0, rd_active = 0;
  int rd_start = 0, rd_end = 0;
  logic [23:0] rd_addr = '0;

  function automatic bit m_busy(int c);
    return (c >= busy_lo) && (c < busy_hi);
  endfunction

  function automatic logic [7:0] m_stat(int c);
    return {~m_busy(c), 2'b00, m_err4, m_err3, 3'b000};
  endfunction

  // dq is registered: it shows the device state of the previous cycle
  function automatic logic [15:0] m_read(int c);
    if (m_mode || m_busy(c - 1)) return {8'h00, m_stat(c - 1)};
    return m_mem[rd_addr[7:0]];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin : cmp
    int rel;
    bit ew, eo;
    if (chk_en) begin
      ew = 1'b0;
      eo = 1'b0;
      if (rd_active) begin
        rel = cyc - rd_start;
        ew  = (rel >= SYNC + 1) && (rel < SYNC + 1 + RD_LAT) && (rel < rd_end);
        eo  = (rel >= SYNC + 1 + RD_LAT) && (rel < rd_end);
      end
      chk("wait", 16'(fwait), 16'(ew));
      chk("dq_oe", 16'(dq_oe), 16'(eo));
      if (eo) chk("dq_o", dq_o, m_read(cyc));
    end
  end

  task automatic bus_write(input logic [23:0] a, input logic [15:0] d);
    int eff;
    @(posedge CLK); #1;
    addr = a; dq_i = d; ce_n = 1'b0; we_n = 1'b0;
    repeat (2) @(posedge CLK); #1;
    we_n = 1'b1;
    eff = cyc + SYNC + 1;
    if (m_busy(eff)) m_err3 = 1'b1;
    else if (m_armed) begin
      m_mem[a[7:0]] = m_mem[a[7:0]] & d;
      m_armed = 1'b0;
      busy_lo = eff;
      busy_hi = eff + PROG_CYC;
    end else begin
      case (d[7:0])
        8'hFF:        m_mode = 1'b0;
        8'h70:        m_mode = 1'b1;
        8'h50:        begin m_err4 = 1'b0; m_err3 = 1'b0; end
        8'h40, 8'h10: begin m_armed = 1'b1; m_mode = 1'b1; end
        default:      m_err4 = 1'b1;
      endcase
    end
    repeat (4) @(posedge CLK); #1;
    ce_n = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  task automatic bus_read(input logic [23:0] a, input int hold, output logic [15:0] first,
                          output logic [15:0] last, output int nwait, output int noe);
    bit got;
    got = 1'b0; first = '0; last = '0; nwait = 0; noe = 0;
    @(posedge CLK); #1;
    addr = a; ce_n = 1'b0; oe_n = 1'b0;
    rd_addr = a; rd_start = cyc; rd_end = 1 << 30; rd_active = 1'b1;
    for (int i = 0; i < hold + 5; i++) begin
      if (i == hold) begin
        @(posedge CLK); #1;
        ce_n = 1'b1; oe_n = 1'b1;
        rd_end = cyc - rd_start + SYNC + 1;
      end
      @(negedge CLK);
      if (fwait) nwait++;
      if (dq_oe) begin
        noe++;
        if (!got) first = dq_o;
        got = 1'b1;
        last = dq_o;
      end
    end
    chk("released", 16'(dq_oe), 16'h0);
    rd_active = 1'b0;
  endtask

  logic [15:0] rf, rl;
  int nw, no;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 16'hFFFF;
    m_mode = 0; m_err4 = 0; m_err3 = 0; m_armed = 0;
    RST_N = 1'b0; addr = '0; dq_i = '0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    repeat (3) @(posedge CLK); #1;
    chk("rst_dq_o", dq_o, 16'h0);
    chk("rst_dq_oe", 16'(dq_oe), 16'h0);
    chk("rst_wait", 16'(fwait), 16'h0);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK); #1;
    chk_en = 1'b1;

    // erased read
    bus_read(24'h000005, 9, rf, rl, nw, no);
    chk("erased_read", rf, 16'hFFFF);
    chk("wait_cycles", 16'(nw), 16'd4);

    // program, observe busy then ready on status
    bus_write(24'h12, 16'h0040);
    bus_write(24'h12, 16'hA5A5);
    bus_read(24'h12, 30, rf, rl, nw, no);
    chk("busy_status", rf, 16'h0000);
    chk("ready_status", rl, 16'h0080);
    bus_write(24'h12, 16'h00FF);
    bus_read(24'h12, 9, rf, rl, nw, no);
    chk("prog_read", rf, 16'hA5A5);

    // AND semantics
    bus_write(24'h12, 16'h0010);
    bus_write(24'h12, 16'h0F0F);
    repeat (20) @(posedge CLK);
    bus_write(24'h0, 16'h00FF);
    bus_read(24'h12, 9, rf, rl, nw, no);
    chk("and_read", rf, 16'h0505);

    // command error and clear
    bus_write(24'h0, 16'h0033);
    bus_write(24'h0, 16'h0070);
    bus_read(24'h0, 9, rf, rl, nw, no);
    chk("err_status", rf, 16'h0090);
    bus_write(24'h0, 16'h0050);
    bus_read(24'h0, 9, rf, rl, nw, no);
    chk("clr_status", rf, 16'h0080);

    // write during busy
    bus_write(24'h20, 16'h0040);
    bus_write(24'h20, 16'hF0F0);
    bus_write(24'h20, 16'h0000);
    repeat (20) @(posedge CLK);
    bus_read(24'h0, 9, rf, rl, nw, no);
    chk("busyv_status", rf, 16'h0088);
    bus_write(24'h0, 16'h0050);
    bus_write(24'h0, 16'h00FF);
    bus_read(24'h20, 9, rf, rl, nw, no);
    chk("busyv_array", rf, 16'hF0F0);

    // aborted read
    bus_read(24'h5, 2, rf, rl, nw, no);
    chk("abort_oe_cnt", 16'(no), 16'd0);
    chk("abort_wait_cnt", 16'(nw), 16'd2);

    // reset during program busy, with a status read on the bus
    bus_write(24'h30, 16'h0040);
    bus_write(24'h30, 16'h1234);
    @(posedge CLK); #1;
    chk_en = 1'b0;
    addr = 24'h30; ce_n = 1'b0; oe_n = 1'b0;
    for (int t = 0; t < 20 && !dq_oe; t++) @(negedge CLK);
    chk("rstbusy_oe", 16'(dq_oe), 16'h1);
    chk("rstbusy_dq", dq_o, 16'h0000);
    RST_N = 1'b0;
    #1;
    chk("rst_async_oe", 16'(dq_oe), 16'h0);
    chk("rst_async_dq", dq_o, 16'h0);
    chk("rst_async_wait", 16'(fwait), 16'h0);
    m_mode = 0; m_err4 = 0; m_err3 = 0; m_armed = 0; busy_lo = 0; busy_hi = 0;
    ce_n = 1'b1; oe_n = 1'b1;
    repeat (3) @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (3) @(posedge CLK); #1;
    chk_en = 1'b1;
    bus_read(24'h30, 9, rf, rl, nw, no);
    chk("rst_keeps_word", rf, 16'h1234);
    bus_write(24'h0, 16'h0070);
    bus_read(24'h0, 9, rf, rl, nw, no);
    chk("rst_status", rf, 16'h0080);

    // address alias
    bus_write(24'h000103, 16'h0040);
    bus_write(24'h000103, 16'h3C3C);
    repeat (20) @(posedge CLK);
    bus_write(24'h0, 16'h00FF);
    bus_read(24'h000003, 9, rf, rl, nw, no);
    chk("alias_read", rf, 16'h3C3C);

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_bpi_responder.md
Name: flash_bpi_responder

Overview:
- Synthesizable responder for the board's 16-bit parallel BPI NOR flash bus: the device end of the bus that the platform's flash initiator drives (addr, dq, wait, we_n, oe_n, ce_n).
- Holds a small word array and implements a reduced command set: read array, read status, word program, clear status.
- Used in simulation and in loopback builds that have no physical flash, so the platform's flash controller can be exercised end to end.

Parameters:
- ADDR_W, 24, width of flash_addr.
- MEM_AW, 8, log2 of the internal word count; the array is addressed by flash_addr[MEM_AW-1:0].
- RD_LAT, 4, number of cycles flash_wait stays asserted before read data is valid. Range 1..15.
- PROG_CYC, 16, number of cycles the busy phase lasts after a program data write. Range 1..255.

Ports:
- CLK  in  1  sole clock; all logic is clocked on its rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- flash_addr  in  ADDR_W  word address from the initiator.
- flash_dq_i  in  16  write data from the bus.
- flash_dq_o  out  16  read data to the bus.
- flash_dq_oe  out  1  high = responder drives dq (the tri-state buffer is at the top level).
- flash_wait  out  1  high = read data not yet valid.
- flash_ce_n  in  1  chip enable, active-low.
- flash_oe_n  in  1  output enable, active-low.
- flash_we_n  in  1  write enable, active-low.

Behaviour:
- Reset: all outputs assert low asynchronously when RST_N falls.
  - flash_dq_o = 0, flash_dq_oe = 0, flash_wait = 0.
  - status = 0x80 (ready), mode = ARRAY, bus FSM = IDLE, cmd FSM = CMD.
  - The memory array is not reset; it powers up at 0xFFFF in every word.
- Input capture:
  - ce_n, oe_n and we_n pass through 2-flop synchronizers, so decisions lag the pins by 2 cycles.
  - addr and dq_i are registered on the same cycle a write or read event is detected. The initiator holds them stable for the whole strobe.
- Read path (bus FSM):
  - IDLE -> RD_WAIT when synced ce_n = 0 and oe_n = 0 and we_n = 1. On this transition wait goes to 1 and the address is latched.
  - RD_WAIT: a counter runs RD_LAT cycles, then the FSM moves to RD_DATA.
  - RD_DATA: dq_o = mem[addr] if mode = ARRAY, or {8'h00, status} if mode = STATUS. dq_oe = 1 and wait = 0.
  - Any state -> IDLE when synced oe_n = 1 or ce_n = 1. dq_oe falls on the following cycle; the bus is released within 1 cycle.
  - If the read is aborted in RD_WAIT, no data is driven and wait returns to 0.
- Write detection: a write is the synced we_n rising edge (0 -> 1) while synced ce_n = 0. Data and address are latched at that edge. A we_n edge while oe_n = 0 is ignored (bus contention) and sets status bit 4.
- Command handling (cmd FSM):
  - In CMD state, the write data byte [7:0] selects the command:
    - 0xFF: mode = ARRAY.
    - 0x70: mode = STATUS.
    - 0x50: clear status bits 4 and 3.
    - 0x40 or 0x10: go to PROG_ARM, mode = STATUS.
    - Any other value: set status bit 4, no other action.
  - PROG_ARM: the next write programs the word: mem[a] <= mem[a] & data, so bits can only be cleared. Then status[7] = 0 and the FSM goes to PROG_BUSY.
  - PROG_BUSY: lasts PROG_CYC cycles, then status[7] = 1 and the FSM returns to CMD.
  - Writes arriving during PROG_BUSY are ignored and set status bit 3.
  - Reads during PROG_BUSY return status whatever the mode is.
  - Programming a 0 over a location whose bit is already 0 has no effect and is not an error.
- Status register bits:
  - [7] ready.
  - [4] command/program error.
  - [3] busy violation.
  - All other bits read 0.
- Reset mid-operation: a pending program is abandoned and the array word keeps any value already written. The read FSM releases dq immediately.
- Address wrap: address bits above MEM_AW are ignored, so address 0x000100 aliases 0x000000 when MEM_AW = 8.

Decomposition:
- Shared package flash_bpi_pkg holds:
  - command codes CMD_READ_ARRAY = 0xFF, CMD_READ_STATUS = 0x70, CMD_CLR_STATUS = 0x50, CMD_PROG = 0x40, CMD_PROG_ALT = 0x10;
  - status bit indices;
  - the bus and cmd FSM state encodings.
- One natural sub-module: flash_bpi_sync, a parametrized 2-flop synchronizer with async active-low reset, instantiated once on the 3-bit strobe vector.

Test Plan:
- Post-reset read: ce_n = 0, oe_n = 0 at addr 0x000005 -> wait = 1 for RD_LAT = 4 cycles, then dq_o = 0xFFFF with dq_oe = 1; raise oe_n -> dq_oe = 0 within 1 cycle.
- Program: write 0x0040 to addr 0x12, then write 0xA5A5 to addr 0x12 -> status reads 0x00 during 16 cycles, then 0x80. Write 0xFF, read addr 0x12 -> 0xA5A5.
- AND semantics: program 0x0F0F over 0xA5A5 at addr 0x12 -> a later read returns 0x0505.
- Errors: write 0x0033 -> status 0x90. Write 0x50 -> status 0x80. A write during PROG_BUSY -> status bit 3 set, and the array is unchanged.
- Aborts: raise oe_n 2 cycles into RD_WAIT -> dq_oe never asserts and wait = 0. Assert RST_N low during PROG_BUSY -> status = 0x80 and mode = ARRAY immediately.
- Alias: program at addr 0x000103 with MEM_AW = 8 -> a read at 0x000003 returns the programmed value.
